// File: rtl/uc_collect_arbiter.sv
// rtl/uc_collect_arbiter.sv - unit-clause collector: engine grant, dup/complement filter, broadcast FIFO
module uc_collect_arbiter #(
  parameter int NUM_ENG = 4,
  parameter int LIT_W   = 8,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     flush,
  input  logic [NUM_ENG-1:0]       eng_valid,
  input  logic [NUM_ENG*LIT_W-1:0] eng_lit,
  output logic [NUM_ENG-1:0]       eng_pop,
  output logic                     out_valid,
  output logic [LIT_W-1:0]         out_lit,
  input  logic                     out_ready,
  output logic                     gst_valid,
  output logic [LIT_W-1:0]         gst_lit,
  output logic                     conflict,
  output logic                     idle,
  output logic [CNT_W-1:0]         dup_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int IW = LIT_W - 1;

  typedef enum logic {ST_RUN, ST_CONF} state_t;
  state_t state_q, state_d;

  logic [LIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rel;
  logic [AW:0]      count;
  logic [RW-1:0]    rr_ptr, gnt_idx;
  logic [LIT_W-1:0] best_key, g_lit;
  logic             gnt_any, grant, hit_dup, hit_comp, lit_null;
  logic             do_push, do_pop, do_dup, do_conf;
  int               rr_e;

  // Priority key orders by variable index first, positive before negated
  function automatic logic [LIT_W-1:0] lit_key(input logic [LIT_W-1:0] l);
    return {l[IW-1:0], l[LIT_W-1]};
  endfunction

  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    best_key = '1;
    rr_e     = 0;
    if (mode) begin
      for (int i = 0; i < NUM_ENG; i++) begin
        if (eng_valid[i] && (!gnt_any || lit_key(eng_lit[i*LIT_W +: LIT_W]) < best_key)) begin
          gnt_any  = 1'b1;
          gnt_idx  = RW'(i);
          best_key = lit_key(eng_lit[i*LIT_W +: LIT_W]);
        end
      end
    end else begin
      for (int k = 0; k < NUM_ENG; k++) begin
        rr_e = (int'(rr_ptr) + k) % NUM_ENG;
        if (!gnt_any && eng_valid[rr_e]) begin
          gnt_any = 1'b1;
          gnt_idx = RW'(rr_e);
        end
      end
    end
  end

  // A pop in the same cycle never frees a slot for the grant
  assign grant   = (state_q == ST_RUN) && !rst && !flush && (count < (AW+1)'(DEPTH)) && gnt_any;
  assign eng_pop = grant ? (NUM_ENG'(1) << gnt_idx) : '0;
  assign g_lit   = eng_lit[int'(gnt_idx)*LIT_W +: LIT_W];

  // Filter covers every occupied entry, including a head leaving this cycle
  always_comb begin
    hit_dup  = 1'b0;
    hit_comp = 1'b0;
    rel      = '0;
    for (int j = 0; j < DEPTH; j++) begin
      rel = AW'(j) - rd_ptr;
      if (({1'b0, rel} < count) && (mem[j][IW-1:0] == g_lit[IW-1:0])) begin
        if (mem[j][LIT_W-1] == g_lit[LIT_W-1]) hit_dup  = 1'b1;
        else                                   hit_comp = 1'b1;
      end
    end
  end

  assign lit_null = (g_lit[IW-1:0] == '0);
  assign do_conf  = grant && !lit_null && hit_comp;
  assign do_dup   = grant && !lit_null && hit_dup && !hit_comp;
  assign do_push  = grant && !lit_null && !hit_dup && !hit_comp;

  assign out_valid = (state_q == ST_RUN) && (count != '0);
  assign out_lit   = mem[rd_ptr];
  assign do_pop    = out_valid && out_ready && !rst && !flush;
  assign conflict  = (state_q == ST_CONF);
  assign idle      = !(|eng_valid) && (count == '0) && !conflict;

  always_comb begin
    state_d = state_q;
    if (do_conf) state_d = ST_CONF;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) state_q <= ST_RUN;
    else              state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= g_lit;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rr_ptr    <= '0;
      dup_cnt   <= '0;
      gst_valid <= 1'b0;
      gst_lit   <= '0;
    end else begin
      gst_valid <= do_push;
      if (do_push) begin
        gst_lit <= g_lit;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (grant && !mode) begin
        if (int'(gnt_idx) == NUM_ENG - 1) rr_ptr <= '0;
        else                              rr_ptr <= gnt_idx + 1'b1;
      end
      if (do_dup && (dup_cnt != '1)) dup_cnt <= dup_cnt + 1'b1;
    end
  end

endmodule
